// File: rtl/mbc_pkg.sv
// Shared constants and types for the multi-kind cartridge memory bank controller.
package mbc_pkg;

   localparam logic [1:0] MBC_KIND_MBC1 = 2'd0;
   localparam logic [1:0] MBC_KIND_MBC3 = 2'd1;
   localparam logic [1:0] MBC_KIND_MBC5 = 2'd2;

   localparam int unsigned RTC_IDX_W = 3;
   localparam logic [RTC_IDX_W-1:0] RTC_SEC = 3'd0;
   localparam logic [RTC_IDX_W-1:0] RTC_MIN = 3'd1;
   localparam logic [RTC_IDX_W-1:0] RTC_HR  = 3'd2;
   localparam logic [RTC_IDX_W-1:0] RTC_DL  = 3'd3;
   localparam logic [RTC_IDX_W-1:0] RTC_DH  = 3'd4;

   // Regions keyed on iadr[15:13] (8 KiB windows) and iadr[15:14] (16 KiB ROM windows)
   localparam logic [2:0] REG_RAM_ENA = 3'b000;
   localparam logic [2:0] REG_BANK_LO = 3'b001;
   localparam logic [2:0] REG_BANK_HI = 3'b010;
   localparam logic [2:0] REG_MODE    = 3'b011;
   localparam logic [2:0] REG_RAM     = 3'b101;
   localparam logic [1:0] ROM_FIXED   = 2'b00;
   localparam logic [1:0] ROM_SWITCH  = 2'b01;

   typedef struct packed {
      logic       carry;
      logic       halt;
      logic [8:0] day;
      logic [4:0] hr;
      logic [5:0] min;
      logic [5:0] sec;
   } rtc_regs_t;

endpackage

// File: rtl/mbc_rtc.sv
// MBC3 real-time clock: live counters, latch sequence and latched read-back copy.
module mbc_rtc
   import mbc_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tick,
   input  logic                 wr,
   input  logic                 latch_wr,
   input  logic [RTC_IDX_W-1:0] idx,
   input  logic [7:0]           wdata,
   output logic [7:0]           rdata
);

   rtc_regs_t live, live_nxt, latched;
   logic      latch_armed;

   // Tick cascade first, then a CPU write overrides the addressed register
   always_comb begin : live_update
      live_nxt = live;
      if (tick && !live.halt) begin
         if (live.sec == 6'd59) begin
            live_nxt.sec = 6'd0;
            if (live.min == 6'd59) begin
               live_nxt.min = 6'd0;
               if (live.hr == 5'd23) begin
                  live_nxt.hr = 5'd0;
                  if (live.day == 9'd511) begin
                     live_nxt.day   = 9'd0;
                     live_nxt.carry = 1'b1;
                  end else begin
                     live_nxt.day = live.day + 9'd1;
                  end
               end else begin
                  live_nxt.hr = live.hr + 5'd1;
               end
            end else begin
               live_nxt.min = live.min + 6'd1;
            end
         end else begin
            live_nxt.sec = live.sec + 6'd1;
         end
      end
      if (wr) begin
         case (idx)
            RTC_SEC: live_nxt.sec      = wdata[5:0];
            RTC_MIN: live_nxt.min      = wdata[5:0];
            RTC_HR:  live_nxt.hr       = wdata[4:0];
            RTC_DL:  live_nxt.day[7:0] = wdata;
            RTC_DH: begin
               live_nxt.day[8] = wdata[0];
               live_nxt.halt   = wdata[6];
               live_nxt.carry  = wdata[7];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         live        <= '0;
         latched     <= '0;
         latch_armed <= 1'b0;
      end else begin
         live <= live_nxt;
         if (latch_wr) begin
            latch_armed <= (wdata == 8'h00);
            if (latch_armed && wdata == 8'h01) latched <= live;
         end
      end
   end

   always_comb begin : read_mux
      rdata = 8'h00;
      case (idx)
         RTC_SEC: rdata = {2'b00, latched.sec};
         RTC_MIN: rdata = {2'b00, latched.min};
         RTC_HR:  rdata = {3'b000, latched.hr};
         RTC_DL:  rdata = latched.day[7:0];
         RTC_DH:  rdata = {latched.carry, latched.halt, 5'b00000, latched.day[8]};
         default: rdata = 8'h00;
      endcase
   end

endmodule

// File: rtl/mbc_multi.sv
// Run-time selectable MBC1/MBC3/MBC5 bank controller; define MBC_RTC_EN to
// build in the MBC3 real-time clock (mbc_rtc).
module mbc_multi
   import mbc_pkg::*;
#(
   parameter  int unsigned ROM_BANK_W = 9,
   parameter  int unsigned RAM_BANK_W = 4,
   localparam int unsigned OADR_W     = ROM_BANK_W + 14
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        kind,
   input  logic              default_mode,
   input  logic [15:0]       iadr,
   input  logic [7:0]        data,
   input  logic              read,
   input  logic              write,
   input  logic              rtc_tick,
   output logic [OADR_W-1:0] oadr,
   output logic              sel_rom,
   output logic              sel_ram,
   output logic              sel_rtc,
   output logic [7:0]        rtc_rdata
);

   localparam int unsigned BANK_TMP_W = 16;

   logic [ROM_BANK_W-1:0] rom_bank, rom_bank_nxt, eff_bank;
   logic [RAM_BANK_W-1:0] ram_bank, ram_bank_nxt;
   logic [BANK_TMP_W-1:0] rom_wide, ram_wide;
   logic                  ena_ram, ena_ram_nxt, mode, mode_nxt, write_q, commit;
   logic                  rtc_sel;
   logic [7:0]            rtc_val;
   logic [2:0]            wreg;
   logic                  kind_mbc1, kind_mbc3;
   logic                  unused;

   assign wreg      = iadr[15:13];
   assign kind_mbc1 = (kind == MBC_KIND_MBC1);
   assign kind_mbc3 = (kind == MBC_KIND_MBC3);
   assign commit    = write & ~write_q;

`ifdef MBC_RTC_EN
   logic [RTC_IDX_W-1:0] rtc_idx, rtc_idx_nxt;
   logic                 rtc_sel_nxt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rtc_sel <= 1'b0;
         rtc_idx <= '0;
      end else begin
         rtc_sel <= rtc_sel_nxt;
         rtc_idx <= rtc_idx_nxt;
      end
   end

   mbc_rtc u_rtc (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (rtc_tick),
      .wr       (commit && wreg == REG_RAM && rtc_sel && ena_ram),
      .latch_wr (commit && kind_mbc3 && wreg == REG_MODE),
      .idx      (rtc_idx),
      .wdata    (data),
      .rdata    (rtc_val)
   );

   assign unused = read;
`else
   assign rtc_sel = 1'b0;
   assign rtc_val = 8'h00;
   assign unused  = read ^ rtc_tick;
`endif

   // Bank-register updates; wide temporaries let oversized fields drop silently
   always_comb begin : write_decode
      rom_wide    = BANK_TMP_W'(rom_bank);
      ram_wide    = BANK_TMP_W'(ram_bank);
      ena_ram_nxt = ena_ram;
      mode_nxt    = mode;
`ifdef MBC_RTC_EN
      rtc_sel_nxt = rtc_sel;
      rtc_idx_nxt = rtc_idx;
`endif
      if (commit) begin
         if (wreg == REG_RAM_ENA) ena_ram_nxt = (data[3:0] == 4'hA);
         if (kind_mbc1) begin
            case (wreg)
               REG_BANK_LO: rom_wide[4:0] = data[4:0];
               REG_BANK_HI: begin
                  if (!mode) rom_wide[6:5] = data[1:0];
                  else       ram_wide[1:0] = data[1:0];
               end
               REG_MODE:    mode_nxt = data[0];
               default: ;
            endcase
         end else if (kind_mbc3) begin
            case (wreg)
               REG_BANK_LO: rom_wide[6:0] = data[6:0];
               REG_BANK_HI: begin
                  if (data[7:3] == 5'd0) begin
                     ram_wide = BANK_TMP_W'(data[2:0]);
`ifdef MBC_RTC_EN
                     rtc_sel_nxt = 1'b0;
                  end else if (data <= 8'h0C) begin
                     rtc_sel_nxt = 1'b1;
                     rtc_idx_nxt = RTC_IDX_W'(data - 8'h08);
`endif
                  end
               end
               default: ;
            endcase
         end else begin
            case (wreg)
               REG_BANK_LO: begin
                  if (!iadr[12]) rom_wide[7:0] = data;
                  else           rom_wide[8]   = data[0];
               end
               REG_BANK_HI: ram_wide = BANK_TMP_W'(data[3:0]);
               default: ;
            endcase
         end
      end
      rom_bank_nxt = ROM_BANK_W'(rom_wide);
      ram_bank_nxt = RAM_BANK_W'(ram_wide);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rom_bank <= '0;
         ram_bank <= '0;
         ena_ram  <= 1'b0;
         mode     <= default_mode;
         write_q  <= 1'b0;
      end else begin
         rom_bank <= rom_bank_nxt;
         ram_bank <= ram_bank_nxt;
         ena_ram  <= ena_ram_nxt;
         mode     <= mode_nxt;
         write_q  <= write;
      end
   end

   // Bank 0 aliasing in the switchable window differs per controller kind
   always_comb begin : eff_bank_calc
      eff_bank = rom_bank;
      if (kind_mbc1 && rom_bank[4:0] == 5'd0) eff_bank[0] = 1'b1;
      else if (kind_mbc3 && rom_bank == '0)   eff_bank = ROM_BANK_W'(1);
   end

   always_comb begin : addr_decode
      oadr      = '0;
      sel_rom   = 1'b0;
      sel_ram   = 1'b0;
      sel_rtc   = 1'b0;
      rtc_rdata = 8'h00;
      if (iadr[15:14] == ROM_FIXED) begin
         sel_rom = 1'b1;
         oadr    = OADR_W'(iadr[13:0]);
      end else if (iadr[15:14] == ROM_SWITCH) begin
         sel_rom = 1'b1;
         oadr    = {eff_bank, iadr[13:0]};
      end else if (wreg == REG_RAM) begin
         oadr      = OADR_W'({ram_bank, iadr[12:0]});
         sel_ram   = ena_ram & ~rtc_sel;
         sel_rtc   = ena_ram & rtc_sel;
         rtc_rdata = rtc_sel ? rtc_val : 8'h00;
      end
      if (!reset_n) begin
         sel_rom   = 1'b0;
         sel_ram   = 1'b0;
         sel_rtc   = 1'b0;
         rtc_rdata = 8'h00;
      end
   end

endmodule

// File: tb/tb_mbc_multi.sv
// Scoreboard bench for mbc_multi: stimulus pushes expected decode results,
// a negedge monitor pops and compares them whenever read is asserted.
module tb_mbc_multi;

   localparam int OW = 23;

   typedef struct packed {
      logic          rom;
      logic          ram;
      logic          rtc;
      logic [OW-1:0] oadr;
      logic [7:0]    rdata;
   } obs_t;

   logic          clk = 1'b0;
   logic          reset_n, default_mode, read, write, rtc_tick;
   logic [1:0]    kind;
   logic [15:0]   iadr;
   logic [7:0]    data;
   logic [OW-1:0] oadr;
   logic          sel_rom, sel_ram, sel_rtc;
   logic [7:0]    rtc_rdata;

   obs_t        exp_q[$];
   logic [15:0] adr_q[$];
   int checks = 0;
   int passes = 0;

   // reference model state
   int m_kind, m_rom, m_ram, m_ena, m_mode, m_rtc_sel;
   bit in_reset;

   always #5 clk = ~clk;

   mbc_multi dut (
      .clk(clk), .reset_n(reset_n), .kind(kind), .default_mode(default_mode),
      .iadr(iadr), .data(data), .read(read), .write(write), .rtc_tick(rtc_tick),
      .oadr(oadr), .sel_rom(sel_rom), .sel_ram(sel_ram), .sel_rtc(sel_rtc),
      .rtc_rdata(rtc_rdata)
   );

   function automatic obs_t mk(logic r, logic m, logic t, int o, int d);
      obs_t e;
      e.rom = r; e.ram = m; e.rtc = t; e.oadr = OW'(o); e.rdata = 8'(d);
      return e;
   endfunction

   function automatic obs_t model_decode(int a);
      obs_t e;
      int   eff;
      e = '0;
      if (a < 'h4000) begin
         e.rom = 1'b1; e.oadr = OW'(a);
      end else if (a < 'h8000) begin
         eff = m_rom;
         if (m_kind == 0 && eff % 32 == 0) eff = eff + 1;
         else if (m_kind == 1 && eff == 0) eff = 1;
         e.rom = 1'b1; e.oadr = OW'(eff * 16384 + a % 16384);
      end else if (a >= 'hA000 && a < 'hC000) begin
         e.oadr = OW'(m_ram * 8192 + a % 8192);
         if (m_rtc_sel != 0) e.rtc = (m_ena != 0);
         else                e.ram = (m_ena != 0);
      end
      if (in_reset) begin
         e.rom = 1'b0; e.ram = 1'b0; e.rtc = 1'b0; e.rdata = 8'h00;
      end
      return e;
   endfunction

   task automatic model_write(int a, int d);
      if (a < 'h2000) m_ena = (d % 16 == 10);
      else if (a < 'h8000) begin
         case (m_kind)
            0: begin
               if (a < 'h4000) m_rom = (m_rom & ~31) | (d & 31);
               else if (a < 'h6000) begin
                  if (m_mode == 0) m_rom = (m_rom & ~'h60) | ((d & 3) << 5);
                  else             m_ram = (m_ram & ~3) | (d & 3);
               end else m_mode = d & 1;
            end
            1: begin
               if (a < 'h4000) m_rom = (m_rom & ~'h7F) | (d & 'h7F);
               else if (a < 'h6000) begin
                  if (d < 8) begin m_ram = d; m_rtc_sel = 0; end
`ifdef MBC_RTC_EN
                  else if (d <= 'h0C) m_rtc_sel = 1;
`endif
               end
            end
            default: begin
               if (a < 'h3000)      m_rom = (m_rom & 'h100) | d;
               else if (a < 'h4000) m_rom = (m_rom & 'hFF) | ((d & 1) << 8);
               else if (a < 'h6000) m_ram = d & 15;
            end
         endcase
      end
      m_rom = m_rom & 511;
      m_ram = m_ram & 15;
   endtask

   always @(negedge clk) begin
      obs_t        got, e;
      logic [15:0] a;
      if (read) begin
         got = {sel_rom, sel_ram, sel_rtc, oadr, rtc_rdata};
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL read_unexpected: got %h with nothing expected", got);
         end else begin
            e = exp_q.pop_front();
            a = adr_q.pop_front();
            if (got === e) passes++;
            else $display("FAIL read@%h: got rom=%b ram=%b rtc=%b oadr=%h rdata=%h, want rom=%b ram=%b rtc=%b oadr=%h rdata=%h",
                          a, got.rom, got.ram, got.rtc, got.oadr, got.rdata,
                          e.rom, e.ram, e.rtc, e.oadr, e.rdata);
         end
      end
   end

   task automatic cpu_read_exp(logic [15:0] a, obs_t e);
      iadr = a; read = 1'b1;
      exp_q.push_back(e); adr_q.push_back(a);
      @(posedge clk); #1;
      read = 1'b0;
   endtask

   task automatic cpu_read(logic [15:0] a);
      cpu_read_exp(a, model_decode(int'(a)));
   endtask

   task automatic cpu_read_rtc(logic [15:0] a, int rd);
      obs_t e;
      e = model_decode(int'(a));
      e.rdata = 8'(rd);
      cpu_read_exp(a, e);
   endtask

   task automatic cpu_write(logic [15:0] a, logic [7:0] d);
      iadr = a; data = d; write = 1'b1;
      @(posedge clk); #1;
      write = 1'b0;
      @(posedge clk); #1;
      model_write(int'(a), int'(d));
   endtask

   task automatic do_reset(int k, logic dm, logic [15:0] probe);
      kind = 2'(k); m_kind = k; default_mode = dm;
      reset_n = 1'b0; in_reset = 1'b1;
      cpu_read(probe);
      m_rom = 0; m_ram = 0; m_ena = 0; m_mode = int'(dm); m_rtc_sel = 0;
      reset_n = 1'b1; in_reset = 1'b0;
   endtask

   task automatic tick();
      rtc_tick = 1'b1;
      @(posedge clk); #1;
      rtc_tick = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic random_phase(int n);
      logic [15:0] a;
      logic [7:0]  d;
      int          r;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            r = $urandom_range(0, 4);
            a = (r == 4) ? 16'hA000 : 16'(r * 'h2000);
            a = a + 16'($urandom_range(0, 'h1FFF));
            d = 8'($urandom);
            if (r == 0 && $urandom_range(0, 1) == 1) d[3:0] = 4'hA;
`ifdef MBC_RTC_EN
            if (m_kind == 1 && r == 2) d = d & 8'h07;
`endif
            cpu_write(a, d);
         end else begin
            cpu_read(16'($urandom));
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; default_mode = 1'b0; read = 1'b0; write = 1'b0;
      rtc_tick = 1'b0; kind = 2'd0; iadr = 16'h0; data = 8'h0;
      m_kind = 0; m_rom = 0; m_ram = 0; m_ena = 0; m_mode = 0; m_rtc_sel = 0;
      in_reset = 1'b1;
      @(posedge clk); #1;
      do_reset(0, 1'b0, 16'h0123);

      // MBC5 directed
      do_reset(2, 1'b0, 16'h0000);
      cpu_write(16'h2000, 8'hFF); cpu_write(16'h3000, 8'h01);
      cpu_write(16'h4000, 8'h03); cpu_write(16'h0000, 8'h0A);
      cpu_read_exp(16'h7FFF, mk(1, 0, 0, 'h7FFFFF, 0));
      cpu_read_exp(16'hA010, mk(0, 1, 0, 'h06010, 0));
      cpu_read_exp(16'h9000, mk(0, 0, 0, 0, 0));
      cpu_read_exp(16'hC000, mk(0, 0, 0, 0, 0));

      // write held for 5 cycles with data changing mid-pulse: only one commit
      iadr = 16'h2000; data = 8'h05; write = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      data = 8'h07;
      repeat (3) begin @(posedge clk); #1; end
      write = 1'b0;
      @(posedge clk); #1;
      model_write('h2000, 'h05);
      cpu_read_exp(16'h4000, mk(1, 0, 0, 'h414000, 0));
      cpu_write(16'h3000, 8'h00); cpu_write(16'h2000, 8'h00);
      cpu_read_exp(16'h4001, mk(1, 0, 0, 'h000001, 0));
      random_phase(80);

      // reset mid-operation, then mode comes from default_mode
      cpu_write(16'h2000, 8'h05); cpu_write(16'h0000, 8'h0A);
      do_reset(0, 1'b1, 16'h4123);
      cpu_read_exp(16'h4000, mk(1, 0, 0, 'h004000, 0));
      cpu_read_exp(16'hA005, mk(0, 0, 0, 'h0005, 0));
      cpu_write(16'h4000, 8'h03);
      cpu_read_exp(16'hA005, mk(0, 0, 0, 'h6005, 0));
      cpu_read_exp(16'h4000, mk(1, 0, 0, 'h004000, 0));
      random_phase(80);

      // MBC1 mode 0
      do_reset(0, 1'b0, 16'h7000);
      cpu_write(16'h2000, 8'h00); cpu_write(16'h4000, 8'h01);
      cpu_read_exp(16'h4123, mk(1, 0, 0, 'h84123, 0));
      random_phase(120);

      // reserved kind behaves as MBC5
      do_reset(3, 1'b0, 16'hA000);
      cpu_write(16'h3000, 8'h01); cpu_write(16'h2000, 8'h00);
      cpu_read_exp(16'h4000, mk(1, 0, 0, 'h400000, 0));
      random_phase(80);

      // MBC3
      do_reset(1, 1'b0, 16'h5555);
      cpu_write(16'h0000, 8'h0A); cpu_write(16'h4000, 8'h02);
      cpu_write(16'h2000, 8'h00);
      cpu_read_exp(16'h4000, mk(1, 0, 0, 'h004000, 0));
      cpu_write(16'h2000, 8'h85);
      cpu_read_exp(16'h4001, mk(1, 0, 0, 'h014001, 0));
`ifndef MBC_RTC_EN
      cpu_write(16'h4000, 8'h0A);
      cpu_read_exp(16'hA123, mk(0, 1, 0, 'h4123, 0));
`endif
      random_phase(120);

`ifdef MBC_RTC_EN
      do_reset(1, 1'b0, 16'h0000);
      cpu_write(16'h0000, 8'h0A);
      cpu_write(16'h4000, 8'h08); cpu_write(16'hA000, 8'd59);
      cpu_write(16'h4000, 8'h09); cpu_write(16'hA000, 8'd59);
      cpu_write(16'h4000, 8'h0A); cpu_write(16'hA000, 8'd23);
      cpu_write(16'h4000, 8'h0B); cpu_write(16'hA000, 8'hFF);
      cpu_write(16'h4000, 8'h0C); cpu_write(16'hA000, 8'h01);
      tick();
      cpu_write(16'h6000, 8'h00); cpu_write(16'h6000, 8'h01);
      cpu_read_rtc(16'hA000, 'h80);
      cpu_write(16'h4000, 8'h0B); cpu_read_rtc(16'hA001, 'h00);
      cpu_write(16'h4000, 8'h0A); cpu_read_rtc(16'hA002, 'h00);
      cpu_write(16'h4000, 8'h08); cpu_read_rtc(16'hB000, 'h00);
      // halted clock must not advance
      cpu_write(16'hA000, 8'h17);
      cpu_write(16'h4000, 8'h0C); cpu_write(16'hA000, 8'h40);
      repeat (10) tick();
      cpu_write(16'h6000, 8'h00); cpu_write(16'h6000, 8'h01);
      cpu_read_rtc(16'hA000, 'h40);
      cpu_write(16'h4000, 8'h08); cpu_read_rtc(16'hA000, 'h17);
      // running again; a broken latch sequence must not copy
      cpu_write(16'h4000, 8'h0C); cpu_write(16'hA000, 8'h00);
      repeat (3) tick();
      cpu_write(16'h6000, 8'h00); cpu_write(16'h6000, 8'h02);
      cpu_write(16'h6000, 8'h01);
      cpu_write(16'h4000, 8'h08); cpu_read_rtc(16'hA000, 'h17);
      cpu_write(16'h6000, 8'h00); cpu_write(16'h6000, 8'h01);
      cpu_read_rtc(16'hA000, 'h1A);
      cpu_write(16'h4000, 8'h03);
      cpu_read_exp(16'hA004, mk(0, 1, 0, 'h6004, 0));
`endif

      repeat (2) @(posedge clk);
      checks++;
      if (exp_q.size() == 0) passes++;
      else $display("FAIL drain: %0d expected reads left unchecked, want 0", exp_q.size());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
